// File: rtl/ualink_rx_parser.sv
// ---------------------------------------------------------------------------
// ualink_rx_parser
//
// AXI4-Stream sink for the request packets forwarded by ualink_turbo64.
// Each packet is two header words followed by payload beats. The block
// decodes opcode, destination and type, counts payload beats, checks
// framing, and emits one status record per packet on a valid/ready port.
// Saturating counters track good writes, good reads and errored packets.
//
// Ports
//   axi_aclk, axi_resetn       clock, asynchronous active-low reset
//   s_axis_*                   stream sink (tstrb and tuser are ignored)
//   stat_valid / stat_ready    status record handshake
//   stat_opcode/dest/len/err   status record fields
//                              err: [0] runt, [1] bad opcode,
//                                   [2] bad type, [3] overlength/data error
//   wr/rd/err_pkt_count        saturating packet statistics
//
// Optional feature (macro UALINK_RX_PAYLOAD_CHECK_EN):
//   payload beat n must equal {8{n[7:0]}}; a mismatch sets err[3] and
//   increments payload_mismatch_count (extra output port). Parsing stays in
//   PAYLOAD on a mismatch.
// ---------------------------------------------------------------------------
module ualink_rx_parser #(
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int MAX_PAYLOAD_WORDS    = 32,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                              axi_aclk,
   input  logic                              axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic                              stat_valid,
   input  logic                              stat_ready,
   output logic [7:0]                        stat_opcode,
   output logic [47:0]                       stat_dest,
   output logic [7:0]                        stat_len,
   output logic [3:0]                        stat_err,
   output logic [CNT_WIDTH-1:0]              wr_pkt_count,
   output logic [CNT_WIDTH-1:0]              rd_pkt_count,
   output logic [CNT_WIDTH-1:0]              err_pkt_count
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
   ,
   output logic [CNT_WIDTH-1:0]              payload_mismatch_count
`endif
);

   typedef enum logic [2:0] {
      S_HDR0    = 3'd0,
      S_HDR1    = 3'd1,
      S_PAYLOAD = 3'd2,
      S_DROP    = 3'd3,
      S_REPORT  = 3'd4,
      S_STALL   = 3'd5
   } state_t;

   localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD_WORDS);

   state_t                state_q, state_d;
   logic                  init_q, init_d;     // low only in the first cycle after reset
   logic                  tready_q, tready_d;
   logic [7:0]            opcode_q, opcode_d;
   logic [47:0]           dest_q, dest_d;
   logic [7:0]            len_q, len_d;
   logic [3:0]            err_q, err_d;
   logic                  stat_valid_q, stat_valid_d;
   logic [7:0]            stat_opcode_q, stat_opcode_d;
   logic [47:0]           stat_dest_q, stat_dest_d;
   logic [7:0]            stat_len_q, stat_len_d;
   logic [3:0]            stat_err_q, stat_err_d;
   logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
   logic [CNT_WIDTH-1:0]  mis_cnt_q, mis_cnt_d;
`endif

   logic       beat_acc;
   logic       load;
   logic [7:0] len_inc;

   // Sideband inputs carry nothing this block needs.
   logic unused_sideband;
   assign unused_sideband = ^{s_axis_tstrb, s_axis_tuser};

   function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign beat_acc = s_axis_tvalid && tready_q;
   assign len_inc  = (&len_q) ? len_q : len_q + 8'd1;

   always_comb begin
      state_d       = state_q;
      init_d        = 1'b1;
      opcode_d      = opcode_q;
      dest_d        = dest_q;
      len_d         = len_q;
      err_d         = err_q;
      load          = 1'b0;
      stat_valid_d  = stat_valid_q;
      stat_opcode_d = stat_opcode_q;
      stat_dest_d   = stat_dest_q;
      stat_len_d    = stat_len_q;
      stat_err_d    = stat_err_q;
      wr_cnt_d      = wr_cnt_q;
      rd_cnt_d      = rd_cnt_q;
      err_cnt_d     = err_cnt_q;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
      mis_cnt_d     = mis_cnt_q;
`endif

      case (state_q)
         S_HDR0: begin
            if (beat_acc) begin
               opcode_d = s_axis_tdata[15:8];
               dest_d   = s_axis_tdata[47:0];
               len_d    = 8'd0;
               err_d    = 4'd0;
               if (s_axis_tdata[15:8] != 8'hFE && s_axis_tdata[15:8] != 8'hFF)
                  err_d[1] = 1'b1;
               if (s_axis_tlast) begin
                  err_d[0] = 1'b1;
                  state_d  = S_REPORT;
               end else begin
                  state_d  = S_HDR1;
               end
            end
         end
         S_HDR1: begin
            if (beat_acc) begin
               if (s_axis_tdata[63:32] != 32'h0000_0008)
                  err_d[2] = 1'b1;
               if (s_axis_tlast) begin
                  err_d[0] = 1'b1;
                  state_d  = S_REPORT;
               end else if (err_d != 4'd0) begin
                  state_d  = S_DROP;
               end else begin
                  state_d  = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (beat_acc) begin
               len_d = len_inc;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
               // len_q is the 0-based index of this payload beat
               if (s_axis_tdata != {8{len_q}}) begin
                  err_d[3]  = 1'b1;
                  mis_cnt_d = cnt_inc(mis_cnt_q);
               end
`endif
               if ({1'b0, len_inc} > MAX_LEN) begin
                  err_d[3] = 1'b1;
                  state_d  = s_axis_tlast ? S_REPORT : S_DROP;
               end else if (s_axis_tlast) begin
                  state_d  = S_REPORT;
               end
            end
         end
         S_DROP: begin
            if (beat_acc) begin
               len_d = len_inc;
               if (s_axis_tlast)
                  state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            if (!stat_valid_q) begin
               load    = 1'b1;
               state_d = S_HDR0;
            end else begin
               state_d = S_STALL;
            end
         end
         S_STALL: begin
            if (stat_ready || !stat_valid_q) begin
               load    = 1'b1;
               state_d = S_HDR0;
            end
         end
         default: state_d = S_HDR0;
      endcase

      // Retire first; a same-cycle load overrides so valid stays high.
      if (stat_valid_q && stat_ready)
         stat_valid_d = 1'b0;

      if (load) begin
         stat_valid_d  = 1'b1;
         stat_opcode_d = opcode_q;
         stat_dest_d   = dest_q;
         stat_len_d    = len_q;
         stat_err_d    = err_q;
         if (err_q != 4'd0)
            err_cnt_d = cnt_inc(err_cnt_q);
         else if (opcode_q == 8'hFE)
            wr_cnt_d  = cnt_inc(wr_cnt_q);
         else
            rd_cnt_d  = cnt_inc(rd_cnt_q);
      end

      // Ready is registered from the next state; init_q holds it low for
      // the first cycle out of reset.
      tready_d = init_q && (state_d == S_HDR0 || state_d == S_HDR1 ||
                            state_d == S_PAYLOAD || state_d == S_DROP);
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q       <= S_HDR0;
         init_q        <= 1'b0;
         tready_q      <= 1'b0;
         opcode_q      <= 8'd0;
         dest_q        <= 48'd0;
         len_q         <= 8'd0;
         err_q         <= 4'd0;
         stat_valid_q  <= 1'b0;
         stat_opcode_q <= 8'd0;
         stat_dest_q   <= 48'd0;
         stat_len_q    <= 8'd0;
         stat_err_q    <= 4'd0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         err_cnt_q     <= '0;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
         mis_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         init_q        <= init_d;
         tready_q      <= tready_d;
         opcode_q      <= opcode_d;
         dest_q        <= dest_d;
         len_q         <= len_d;
         err_q         <= err_d;
         stat_valid_q  <= stat_valid_d;
         stat_opcode_q <= stat_opcode_d;
         stat_dest_q   <= stat_dest_d;
         stat_len_q    <= stat_len_d;
         stat_err_q    <= stat_err_d;
         wr_cnt_q      <= wr_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         err_cnt_q     <= err_cnt_d;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
         mis_cnt_q     <= mis_cnt_d;
`endif
      end
   end

   assign s_axis_tready = tready_q;
   assign stat_valid    = stat_valid_q;
   assign stat_opcode   = stat_opcode_q;
   assign stat_dest     = stat_dest_q;
   assign stat_len      = stat_len_q;
   assign stat_err      = stat_err_q;
   assign wr_pkt_count  = wr_cnt_q;
   assign rd_pkt_count  = rd_cnt_q;
   assign err_pkt_count = err_cnt_q;
`ifdef UALINK_RX_PAYLOAD_CHECK_EN
   assign payload_mismatch_count = mis_cnt_q;
`endif

endmodule
